// File: rtl/stage4_memory_writeback_if.sv
// Data-memory request/acknowledge bus between pipeline stage 4 (master) and memory (slave).
// Request fields are held stable by the master while MemReq is high.
interface stage4_memory_writeback_if #(
  parameter int DATA_W = 16
);
  logic              MemReq;
  logic              MemWe;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemRData, MemAck
  );
endinterface

// File: rtl/stage4_memory_writeback.sv
// Stage 4: optional data-memory load/store, then register-file writeback.
// Latency: ALU results write back 1 cycle after accept; memory ops 1 cycle after MemAck.
// Backpressure: Stall holds upstream for the whole access; STAGE4_MEM_TIMEOUT_EN adds a watchdog.
module stage4_memory_writeback #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                InValid,
  input  logic [DATA_W-1:0]   ResOut,
  input  logic [DATA_W-1:0]   StoreData,
  input  logic [REG_W-1:0]    DestReg,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                RegWrite,
  stage4_memory_writeback_if.master memBus,
  output logic                WBEn,
  output logic [REG_W-1:0]    WBReg,
  output logic [DATA_W-1:0]   WBData,
  output logic                Stall,
  output logic                MemTimeout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  state_t              stateNext;
  logic                accept;
  logic                isMem;
  logic                ackHit;
  logic                timeoutHit;
  logic                memWeQ;
  logic                regWriteQ;
  logic [DATA_W-1:0]   memAddrQ;
  logic [DATA_W-1:0]   memWDataQ;

  assign accept = (state == IDLE) && InValid;
  assign isMem  = MemRead | MemWrite;
  assign ackHit = (state == ACCESS) && memBus.MemAck;

`ifdef STAGE4_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] waitCnt;
  logic             timeoutQ;

  // waitCnt holds the number of ACCESS cycles already completed; it saturates.
  assign timeoutHit = (state == ACCESS) && !memBus.MemAck
                      && (waitCnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      if (accept && isMem) begin
        waitCnt <= '0;
      end else if ((state == ACCESS) && (waitCnt != CNT_W'(TIMEOUT))) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (timeoutHit) begin
        timeoutQ <= 1'b1;
      end
    end
  end

  assign MemTimeout = timeoutQ;
`else
  assign timeoutHit = 1'b0;
  assign MemTimeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && isMem) begin
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (ackHit || timeoutHit) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      memWeQ    <= 1'b0;
      regWriteQ <= 1'b0;
      memAddrQ  <= '0;
      memWDataQ <= '0;
      WBEn      <= 1'b0;
      WBReg     <= '0;
      WBData    <= '0;
    end else begin
      WBEn <= 1'b0;
      if (accept) begin
        WBReg <= DestReg;
        if (isMem) begin
          // A simultaneous read+write request is treated as a write.
          memWeQ    <= MemWrite;
          regWriteQ <= RegWrite;
          memAddrQ  <= ResOut;
          memWDataQ <= StoreData;
        end else begin
          WBEn   <= RegWrite;
          WBData <= ResOut;
        end
      end
      if (ackHit && !memWeQ) begin
        WBEn   <= regWriteQ;
        WBData <= memBus.MemRData;
      end
    end
  end

  assign Stall           = (state == ACCESS);
  assign memBus.MemReq   = (state == ACCESS);
  assign memBus.MemWe    = memWeQ;
  assign memBus.MemAddr  = memAddrQ;
  assign memBus.MemWData = memWDataQ;

endmodule

// File: tb/tb_stage4_memory_writeback.sv
// Directed plus randomized bench for stage4_memory_writeback against a per-instruction transaction model.
module tb_stage4_memory_writeback;

  logic        CLK;
  logic        nRST;
  logic        InValid;
  logic [15:0] ResOut;
  logic [15:0] StoreData;
  logic [3:0]  DestReg;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic        WBEn;
  logic [3:0]  WBReg;
  logic [15:0] WBData;
  logic        Stall;
  logic        MemTimeout;

  int tests = 0;
  int fails = 0;
  int cnt;

  stage4_memory_writeback_if #(.DATA_W(16)) memBus ();

  stage4_memory_writeback #(.DATA_W(16), .REG_W(4), .TIMEOUT(15)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .InValid    (InValid),
    .ResOut     (ResOut),
    .StoreData  (StoreData),
    .DestReg    (DestReg),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .memBus     (memBus.master),
    .WBEn       (WBEn),
    .WBReg      (WBReg),
    .WBData     (WBData),
    .Stall      (Stall),
    .MemTimeout (MemTimeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    ResOut    = 16'($urandom);
    StoreData = 16'($urandom);
    DestReg   = 4'($urandom);
    MemRead   = 1'($urandom);
    MemWrite  = 1'($urandom);
    RegWrite  = 1'($urandom);
  endtask

  // Presents one instruction at the current negedge and checks it to completion.
  // Returns at the negedge of its writeback cycle, so a following call is back-to-back.
  task automatic runInstr(input bit rd, input bit wr, input bit rw,
                          input logic [15:0] res, input logic [15:0] sd,
                          input logic [3:0] dst, input int dly, input logic [15:0] rdat);
    bit          isMem;
    bit          expWb;
    logic [15:0] expData;
    isMem   = rd | wr;
    expWb   = isMem ? (!wr && rw) : rw;
    expData = isMem ? rdat : res;
    InValid = 1'b1; MemRead = rd; MemWrite = wr; RegWrite = rw;
    ResOut = res; StoreData = sd; DestReg = dst;
    @(negedge CLK);
    InValid = 1'b0;
    scramble();
    if (isMem) begin
      for (int k = 0; k <= dly; k++) begin
        chk("acc_stall", Stall, 1);
        chk("acc_memreq", memBus.MemReq, 1);
        chk("acc_memwe", memBus.MemWe, wr);
        chk("acc_memaddr", memBus.MemAddr, res);
        chk("acc_memwdata", memBus.MemWData, sd);
        chk("acc_wben", WBEn, 0);
        scramble();
        InValid = 1'($urandom);
        memBus.MemAck   = (k == dly);
        memBus.MemRData = (k == dly) ? rdat : 16'($urandom);
        @(negedge CLK);
      end
      memBus.MemAck = 1'b0;
      InValid = 1'b0;
    end
    chk("done_stall", Stall, 0);
    chk("done_memreq", memBus.MemReq, 0);
    chk("wben", WBEn, expWb);
    if (expWb) begin
      chk("wbdata", WBData, expData);
      chk("wbreg", WBReg, dst);
    end
  endtask

  initial begin
    nRST = 1'b0; InValid = 1'b0;
    ResOut = '0; StoreData = '0; DestReg = '0;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    memBus.MemAck = 1'b0; memBus.MemRData = '0;
    repeat (2) @(negedge CLK);

    chk("rst_wben", WBEn, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_memreq", memBus.MemReq, 0);
    chk("rst_memwe", memBus.MemWe, 0);
    chk("rst_timeout", MemTimeout, 0);
    chk("rst_memaddr", memBus.MemAddr, 0);
    chk("rst_memwdata", memBus.MemWData, 0);
    chk("rst_wbdata", WBData, 0);
    chk("rst_wbreg", WBReg, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Passthrough with a stray MemAck in IDLE, which must be ignored.
    memBus.MemAck = 1'b1;
    runInstr(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 4'd3, 0, 16'h0000);
    memBus.MemAck = 1'b0;
    @(negedge CLK);
    chk("idle_ack_stall", Stall, 0);
    chk("idle_ack_wben", WBEn, 0);

    runInstr(1'b1, 1'b0, 1'b1, 16'h0040, 16'h5555, 4'd5, 2, 16'hBEEF);
    runInstr(1'b1, 1'b1, 1'b1, 16'h0080, 16'h00FF, 4'd6, 0, 16'hDEAD);

    // Back-to-back: passthrough immediately followed by a 1-cycle load.
    runInstr(1'b0, 1'b0, 1'b1, 16'hA5A5, 16'h0000, 4'd7, 0, 16'h0000);
    runInstr(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 4'd8, 0, 16'hC0DE);

    for (int i = 0; i < 40; i++) begin
      runInstr(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               4'($urandom), int'($urandom_range(0, 4)), 16'($urandom));
    end
    @(negedge CLK);

    // Asynchronous reset in the second ACCESS cycle.
    InValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
    ResOut = 16'h0200; DestReg = 4'd9;
    @(negedge CLK);
    InValid = 1'b0;
    chk("mid_memreq_pre", memBus.MemReq, 1);
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("mid_memreq", memBus.MemReq, 0);
    chk("mid_stall", Stall, 0);
    chk("mid_wben", WBEn, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("mid_after_wben", WBEn, 0);
    runInstr(1'b0, 1'b0, 1'b1, 16'h4321, 16'h0000, 4'd2, 0, 16'h0000);

`ifdef STAGE4_MEM_TIMEOUT_EN
    InValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
    ResOut = 16'h0300; DestReg = 4'd4;
    @(negedge CLK);
    InValid = 1'b0;
    cnt = 0;
    while (memBus.MemReq === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge CLK);
    end
    chk("wd_cycles", cnt, 15);
    chk("wd_timeout", MemTimeout, 1);
    chk("wd_wben", WBEn, 0);
    chk("wd_stall", Stall, 0);
    runInstr(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 4'd1, 0, 16'h0000);
    chk("wd_sticky", MemTimeout, 1);
`else
    InValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
    ResOut = 16'h0300; DestReg = 4'd4;
    @(negedge CLK);
    InValid = 1'b0;
    repeat (100) @(negedge CLK);
    chk("nowd_memreq", memBus.MemReq, 1);
    chk("nowd_stall", Stall, 1);
    chk("nowd_timeout", MemTimeout, 0);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    runInstr(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0000, 4'd1, 0, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage4_memory_writeback.md
# stage4_memory_writeback

Fourth pipeline stage of the 16-bit datapath, directly downstream of the stage-3 ALU/shifter integration.
- Consumes the registered stage-3 result (`ResOut`) plus stage-3 control.
- Performs an optional data-memory load or store through a request/acknowledge handshake.
- Drives the register-file writeback port.
- Stalls upstream stages while a memory access is outstanding.

## Interface
Parameters:
- `DATA_W`, 16, datapath and address width
- `REG_W`, 4, destination register index width
- `TIMEOUT`, 15, maximum cycles `MemReq` is held without `MemAck` (watchdog builds only)

Ports:
- `CLK`  in  1  clock; all state updates on rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `InValid`  in  1  stage-3 presents an instruction this cycle
- `ResOut`  in  DATA_W  stage-3 result: memory address for load/store, writeback value otherwise
- `StoreData`  in  DATA_W  value to store
- `DestReg`  in  REG_W  writeback register index
- `MemRead`, `MemWrite`, `RegWrite`  in  1 each  instruction control
- `MemReq`  out  1  memory request, held until ack or timeout
- `MemWe`  out  1  1 = write, 0 = read; valid while `MemReq`
- `MemAddr`, `MemWData`  out  DATA_W  request address and store data
- `MemRData`  in  DATA_W  read data, valid with `MemAck`
- `MemAck`  in  1  access complete
- `WBEn`  out  1  register-file write strobe, one cycle wide
- `WBReg`  out  REG_W  register index for the write
- `WBData`  out  DATA_W  data for the write
- `Stall`  out  1  upstream must hold its inputs
- `MemTimeout`  out  1  sticky watchdog error flag

## Operation
The FSM has two states, IDLE and ACCESS.

IDLE:
- The stage accepts the input when `InValid`=1.
- If `MemWrite` or `MemRead` is set, it latches `ResOut`→`MemAddr`, `StoreData`→`MemWData`, `DestReg` and `RegWrite`, then moves to ACCESS.
- When `MemRead`=1 and `MemWrite`=1 together, the access is a write; the read is ignored.
- If neither memory bit is set, the next cycle has `WBEn`=`RegWrite`, `WBData`=`ResOut` and `WBReg`=`DestReg`. The state stays IDLE.

ACCESS:
- `MemReq`=1 and `MemWe`=latched write bit. Address and data are held stable.
- `MemAck` is sampled only in ACCESS.
- On `MemAck` the state returns to IDLE.
- On a read ack, the next cycle has `WBData`=`MemRData` captured at the ack edge and `WBEn`=latched `RegWrite`.
- On a write ack, `WBEn` stays 0.

Common rules:
- `Stall` = (state==ACCESS), as a registered state decode. Inputs are ignored while in ACCESS.
- `WBEn` is 1 for exactly one cycle per completed instruction, else 0.
- No arithmetic is performed on data. The wait counter is `$clog2(TIMEOUT+1)` bits, cleared on entry to ACCESS, and never wraps.

## Timing
- Reset (`nRST`=0, async): state IDLE. `MemReq`, `MemWe`, `WBEn`, `Stall` and `MemTimeout` = 0; `MemAddr`, `MemWData`, `WBData` and `WBReg` = 0. Reset during ACCESS drops `MemReq` immediately; the access is abandoned and no writeback occurs.
- Non-memory latency: accepted at edge N, `WBEn` high in cycle N+1.
- Memory latency: accepted at edge N, then `MemReq` and `Stall` high from N+1. If `MemAck` is sampled at edge M, `MemReq` and `Stall` are low and `WBEn` (reads) is high in cycle M+1.
- `MemAck` high in the first ACCESS cycle: 1-cycle access, so `Stall` is high for exactly one cycle.
- `MemAck` while IDLE is ignored.
- Back-to-back: a new instruction is accepted in the same cycle as the previous instruction's `WBEn`.

## Configuration
- `STAGE4_MEM_TIMEOUT_EN` defined: the watchdog counts ACCESS cycles. After `TIMEOUT` cycles without `MemAck`, on the next edge the block drops `MemReq`, sets `MemTimeout`=1 (held until reset), suppresses the writeback and returns to IDLE.
- Macro undefined: no counter; ACCESS waits indefinitely; `MemTimeout` is tied to 0.

## Test plan
- ALU passthrough: `InValid`=1, `RegWrite`=1, `ResOut`=16'h1234, `DestReg`=3 → next cycle `WBEn`=1, `WBData`=16'h1234, `WBReg`=3, `Stall`=0.
- Load, 3-cycle ack: `MemRead`=1, `ResOut`=16'h0040, memory returns 16'hBEEF → `MemReq`/`Stall` high 3 cycles with `MemAddr`=16'h0040 and `MemWe`=0, then `WBEn`=1 and `WBData`=16'hBEEF for one cycle.
- Store with `MemRead`=`MemWrite`=1, `StoreData`=16'h00FF, immediate ack → `MemWe`=1 and `MemWData`=16'h00FF for one cycle, no `WBEn`.
- Reset asserted in the second ACCESS cycle → `MemReq`, `Stall` and `WBEn` go 0 with no clock edge; after release, a passthrough works normally.
- Watchdog (macro defined, `TIMEOUT`=15), `MemAck` never asserted → `MemReq` high exactly 15 cycles, then `MemTimeout`=1 and `WBEn`=0. Macro undefined: `MemReq` is still high after 100 cycles.
- Back-to-back: passthrough followed by a 1-cycle-ack load → two `WBEn` pulses, with `Stall` high for exactly one cycle between them.
